// File: rtl/axis_arb_rr.sv
// axis_arb_rr: NUM_SRC-input AXI-Stream packet arbiter with round-robin fairness.
// A grant is locked for a whole packet (through the tlast beat). Data path is a
// zero-latency combinational mux; each packet costs one arbitration bubble.
// Optional macro AXIS_ARB_TID_EN adds m_axis_tid (source index sideband).
module axis_arb_rr #(
  parameter  int NUM_SRC = 4,
  parameter  int DATA_W  = 8,
  localparam int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [NUM_SRC-1:0]        s_axis_tvalid,
  output logic [NUM_SRC-1:0]        s_axis_tready,
  input  logic [NUM_SRC*DATA_W-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]        s_axis_tlast,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic [DATA_W-1:0]         m_axis_tdata,
  output logic                      m_axis_tlast,
  output logic [IDX_W-1:0]          grant_idx,
  output logic                      busy,
  output logic [15:0]               pkt_cnt
`ifdef AXIS_ARB_TID_EN
  ,
  output logic [IDX_W-1:0]          m_axis_tid
`endif
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0] pick, cand;
  logic             found;
  logic             last_hs;

  // Round-robin search: first requester after rr_q, wrapping modulo NUM_SRC
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int unsigned i = 1; i <= NUM_SRC; i++) begin
      cand = IDX_W'((32'(rr_q) + i) % NUM_SRC);
      if (!found && s_axis_tvalid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Pass-through mux from the locked source; everything idles at zero otherwise
  always_comb begin
    s_axis_tready = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    if (state_q == BUSY) begin
      m_axis_tvalid          = s_axis_tvalid[grant_q];
      m_axis_tdata           = s_axis_tdata[grant_q*DATA_W +: DATA_W];
      m_axis_tlast           = s_axis_tlast[grant_q];
      s_axis_tready[grant_q] = m_axis_tready;
    end
  end

  assign last_hs = m_axis_tvalid & m_axis_tready & m_axis_tlast;

  // Next-state: lock on a request in IDLE, release after the tlast handshake
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (last_hs) begin
          state_d = IDLE;
          rr_d    = grant_q;
          cnt_d   = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset; rr_q starts at the
  // last source so source 0 wins the first arbitration
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= IDX_W'(NUM_SRC - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant_idx = grant_q;
  assign busy      = (state_q == BUSY);
  assign pkt_cnt   = cnt_q;

`ifdef AXIS_ARB_TID_EN
  assign m_axis_tid = (state_q == BUSY) ? grant_q : '0;
`endif

endmodule

// File: doc/axis_arb_rr.md
Name: axis_arb_rr

Overview:
Parametrised N-input AXI-Stream packet arbiter with round-robin fairness. It multiplexes NUM_SRC upstream AXIS masters onto one downstream AXIS slave. The grant is held for a whole packet, up to and including the tlast beat. Full tready backpressure passes from the downstream slave to the granted source only. It sits between the stream producers and the shared stream consumer (DMA/FIFO) in the AXIS datapath.

Parameters:
NUM_SRC, 4, number of upstream sources; legal range 2..16.
DATA_W, 8, tdata width in bits; 1..512.
IDX_W, $clog2(NUM_SRC), width of the grant index; derived, not overridden.

Ports:
aclk  in  1  clock; all logic on the rising edge.
aresetn  in  1  synchronous active-low reset.
s_axis_tvalid  in  NUM_SRC  per-source tvalid; bit k = source k.
s_axis_tready  out  NUM_SRC  per-source tready.
s_axis_tdata  in  NUM_SRC*DATA_W  packed tdata; source k occupies [k*DATA_W +: DATA_W].
s_axis_tlast  in  NUM_SRC  per-source tlast.
m_axis_tvalid  out  1  downstream tvalid.
m_axis_tready  in  1  downstream tready.
m_axis_tdata  out  DATA_W  downstream tdata.
m_axis_tlast  out  1  downstream tlast.
grant_idx  out  IDX_W  index of the current owner; valid only while busy=1.
busy  out  1  high while a packet is locked to a source.
pkt_cnt  out  16  number of packets completed since reset; wraps 0xFFFF->0x0000.

Behaviour:
- Reset (aresetn=0 at a posedge): state=IDLE, busy=0, grant_idx=0, pkt_cnt=0, rr_ptr=NUM_SRC-1 (source 0 has top priority first).
- Outputs during and after reset: all s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0.
- FSM states: IDLE, BUSY.
- IDLE, no tvalid high: stay in IDLE. All outputs stay 0 and all treadys stay 0.
- IDLE, one or more tvalid high: choose the first requesting source searching rr_ptr+1, rr_ptr+2, ... modulo NUM_SRC. Register it into grant_idx and go to BUSY next cycle. No beat transfers in the IDLE cycle.
- BUSY, combinational pass-through of the granted source g:
  - m_axis_tvalid = s_axis_tvalid[g]; m_axis_tdata = tdata slice g; m_axis_tlast = s_axis_tlast[g].
  - s_axis_tready[g] = m_axis_tready; all other s_axis_tready bits = 0.
  - Zero-latency data path; the only added latency is the 1-cycle arbitration bubble per packet.
- BUSY, handshake on the tlast beat (m_axis_tvalid & m_axis_tready & m_axis_tlast): next cycle state=IDLE, rr_ptr=g, pkt_cnt+1.
- BUSY, all other beats: stay in BUSY. The grant never changes mid-packet, even if the owner drops tvalid. Gaps inside a packet are legal and are passed through as m_axis_tvalid=0.
- Stall: with m_axis_tready=0, no beat is lost or duplicated. tdata/tlast follow the source, which must hold them stable per AXIS rules.
- Fairness: with all sources continuously requesting, grants rotate 0,1,2,...,NUM_SRC-1,0,...
- A source requesting in the same cycle a packet ends competes in the next IDLE cycle. It has no advantage over others beyond the rr_ptr order.
- Single-beat packet (tlast on the first beat): IDLE -> BUSY -> IDLE, 2 cycles minimum per packet.
- Reset mid-packet: abort immediately to the reset state. The partial packet is not terminated downstream; recovery is the upstream's responsibility.
- m_axis_tvalid never depends combinationally on m_axis_tready.

Optional Feature:
AXIS_ARB_TID_EN:
- Defined: adds output port m_axis_tid [IDX_W-1:0]. It equals grant_idx while busy=1 and is 0 otherwise (including in reset). It is sideband-aligned with every beat, so the consumer can demultiplex by source.
- Not defined: the port is absent and there is no extra logic. All other behaviour is identical.

Test Plan:
All scenarios use NUM_SRC=4, DATA_W=8.
- Single source: src1 sends 3 beats 0x11,0x22,0x33 (tlast on 0x33), m_axis_tready=1 -> same 3 beats out in order with tlast on 0x33. Exactly 1 idle cycle before the first beat. grant_idx=1, pkt_cnt=1, then IDLE.
- Round-robin: all 4 sources hold 2-beat packets, tdata = 0xA0+k; run 8 packets -> grant order 0,1,2,3,0,1,2,3 and pkt_cnt=8.
- Packet lock: src0 mid-packet, src2 raises tvalid -> src2 tready stays 0 until src0's tlast handshake. Then src2 is granted after 1 idle cycle.
- Backpressure: toggle m_axis_tready 1,0,0,1 during a 4-beat src3 packet (0x01..0x04) -> output sequence is exactly 0x01..0x04. s_axis_tready[3] mirrors m_axis_tready, and there are no duplicates.
- Reset mid-packet: assert aresetn=0 on the 2nd beat of a src1 packet -> next cycle all outputs 0, pkt_cnt=0. The first packet after reset goes to src0 when src0 and src1 both request.
- TID/wrap: with AXIS_ARB_TID_EN, m_axis_tid equals the source index on every beat. Preload by running 65536 single-beat packets -> pkt_cnt wraps to 0x0000.
